// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources, with bounded bursts.
// Optional tx_done watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic                      err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt, owner, owner_nxt, pick_idx;
  logic                pick_valid;
  logic [3:0]          burst_cnt, burst_nxt;
  logic                last_f, last_nxt;
  logic [NUM_REQ-1:0]  grant_nxt, ack_nxt;
  logic                tx_start_nxt, err_nxt;
  logic [DATA_W-1:0]   tx_data_nxt;
  logic                do_send, do_release, do_timeout, timeout_hit;

  // First requesting index at or after ptr, wrapping; iterate backwards so the nearest one wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx[IDX_W-1:0];
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (!rst_n)                 timer <= '0;
    else if (state != WAIT_DONE) timer <= '0;
    else                        timer <= timer + 1'b1;
  end

  assign timeout_hit = (state == WAIT_DONE) && (timer == TMR_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // tx_done arriving while tx_start is still high belongs to no byte of ours and is ignored.
  always_comb begin
    state_nxt  = state;
    do_send    = 1'b0;
    do_release = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: if (pick_valid) state_nxt = SEND;
      SEND: begin
        if (!req[owner]) begin
          do_release = 1'b1;
          state_nxt  = IDLE;
        end else if (!tx_busy) begin
          do_send   = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done && !tx_start) begin
          if (last_f || burst_cnt == 4'(MAX_BURST) || !req[owner]) begin
            do_release = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end else if (timeout_hit) begin
          do_release = 1'b1;
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt    = grant;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    burst_nxt    = burst_cnt;
    last_nxt     = last_f;
    tx_data_nxt  = tx_data;
    ack_nxt      = '0;
    tx_start_nxt = 1'b0;
    err_nxt      = do_timeout;
    if (state == IDLE && pick_valid) begin
      grant_nxt           = '0;
      grant_nxt[pick_idx] = 1'b1;
      owner_nxt           = pick_idx;
      burst_nxt           = '0;
    end
    if (do_send) begin
      tx_start_nxt = 1'b1;
      ack_nxt      = grant;
      tx_data_nxt  = req_data[owner*DATA_W +: DATA_W];
      last_nxt     = req_last[owner];
      burst_nxt    = burst_cnt + 4'd1;
    end
    if (do_release) begin
      grant_nxt = '0;
      ptr_nxt   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant     <= '0;
      ack       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      err       <= 1'b0;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      last_f    <= 1'b0;
    end else begin
      grant     <= grant_nxt;
      ack       <= ack_nxt;
      tx_start  <= tx_start_nxt;
      tx_data   <= tx_data_nxt;
      err       <= err_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_nxt;
      last_f    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed reset/latency/drop cases plus random byte
// queues compared against a transaction-order model of round-robin with bounded bursts.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int QD        = 8;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_last = '0;
  logic [NUM_REQ-1:0]        ack, grant;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy = 1'b0;
  logic                      tx_done = 1'b0;
  logic                      err;

  int errors = 0;
  int checks = 0;

  bit          auto_on = 1'b0;
  logic [7:0]  bytes [NUM_REQ][QD];
  bit          lastf [NUM_REQ][QD];
  int          len [NUM_REQ];
  int          pos [NUM_REQ];
  int          exp_src [$];
  logic [7:0]  exp_dat [$];
  int          model_ptr = 0;
  bit          xbusy = 1'b0;
  int          xcount = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TIMEOUT_CYC(50000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    if ($onehot(v))
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pos[i] < len[i]) begin
        req[i]                        = 1'b1;
        req_data[i*DATA_W +: DATA_W]  = bytes[i][pos[i]];
        req_last[i]                   = lastf[i][pos[i]];
      end else begin
        req[i]      = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge. In auto mode this also
  // plays the transmitter and the byte sources.
  task automatic tick();
    int g;
    @(posedge clk);
    #1;
    checkOutput("err_zero", {31'd0, err}, 0);
    checkOutput("grant_onehot0", {31'd0, $onehot0(grant)}, 1);
    checkOutput("ack_with_start", {31'd0, (ack != '0)}, {31'd0, tx_start});
    if (auto_on) begin
      tx_done = 1'b0;
      if (tx_start) begin
        g = onehot_idx(ack);
        checkOutput("ack_is_grant", {28'd0, ack}, {28'd0, grant});
        if (exp_src.size() == 0) begin
          checkOutput("extra_start", 1, 0);
        end else begin
          checkOutput("src", g, exp_src.pop_front());
          checkOutput("data", {24'd0, tx_data}, {24'd0, exp_dat.pop_front()});
        end
        if (g >= 0) pos[g]++;
        xbusy  = 1'b1;
        xcount = $urandom_range(1, 12);
      end else if (xbusy) begin
        xcount--;
        if (xcount == 0) begin
          xbusy   = 1'b0;
          tx_done = 1'b1;
        end
      end
      tx_busy = xbusy || ($urandom_range(0, 3) == 0);
      drive_sources();
    end
  endtask

  // Expected transmit order from the queues alone: pick the first non-empty queue from ptr,
  // send until a last flag, MAX_BURST bytes or the queue empties, then rotate past that owner.
  task automatic build_model();
    int p [NUM_REQ];
    int g, c, cnt;
    bit done;
    for (int i = 0; i < NUM_REQ; i++) p[i] = 0;
    while (1) begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (model_ptr + k) % NUM_REQ;
        if (g < 0 && p[c] < len[c]) g = c;
      end
      if (g < 0) break;
      cnt  = 0;
      done = 1'b0;
      while (!done) begin
        exp_src.push_back(g);
        exp_dat.push_back(bytes[g][p[g]]);
        done = lastf[g][p[g]];
        p[g]++;
        cnt++;
        if (cnt == MAX_BURST || p[g] == len[g]) done = 1'b1;
      end
      model_ptr = (g + 1) % NUM_REQ;
    end
  endtask

  task automatic applyStimulus(input int round);
    int cycles;
    for (int i = 0; i < NUM_REQ; i++) begin
      len[i] = $urandom_range(0, QD);
      pos[i] = 0;
      for (int j = 0; j < QD; j++) begin
        bytes[i][j] = 8'($urandom);
        lastf[i][j] = ($urandom_range(0, 3) == 0);
      end
    end
    build_model();
    $display("[TB] round %0d: %0d bytes queued", round, exp_src.size());
    auto_on = 1'b1;
    drive_sources();
    cycles = 0;
    while ((exp_src.size() != 0 || xbusy) && cycles < 3000) begin
      tick();
      cycles++;
    end
    checkOutput("round_budget", {31'd0, (cycles < 3000)}, 1);
    repeat (4) tick();
    checkOutput("round_grant_idle", {28'd0, grant}, 0);
    checkOutput("round_left", exp_src.size(), 0);
    exp_src.delete();
    exp_dat.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b1111;
    req_data = 32'hA5A5_A5A5;
    repeat (3) begin
      tick();
      checkOutput("reset_grant", {28'd0, grant}, 0);
      checkOutput("reset_ack", {28'd0, ack}, 0);
      checkOutput("reset_start", {31'd0, tx_start}, 0);
      checkOutput("reset_data", {24'd0, tx_data}, 0);
    end

    rst_n   = 1'b1;
    tx_busy = 1'b1;
    tick();
    checkOutput("first_grant", {28'd0, grant}, 32'h1);
    repeat (2) begin
      tick();
      checkOutput("busy_no_start", {31'd0, tx_start}, 0);
      checkOutput("busy_hold_grant", {28'd0, grant}, 32'h1);
    end
    req = 4'b1110;
    tick();
    checkOutput("drop_release", {28'd0, grant}, 0);
    checkOutput("drop_no_ack", {28'd0, ack}, 0);
    tick();
    checkOutput("ptr_after_drop", {28'd0, grant}, 32'h2);

    rst_n   = 1'b0;
    req     = '0;
    tx_busy = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    req               = 4'b0100;
    req_data[23:16]   = 8'h41;
    req_last          = 4'b0100;
    tick();
    checkOutput("single_grant", {28'd0, grant}, 32'h4);
    checkOutput("single_no_early_start", {31'd0, tx_start}, 0);
    tick();
    checkOutput("single_start", {31'd0, tx_start}, 1);
    checkOutput("single_ack", {28'd0, ack}, 32'h4);
    checkOutput("single_data", {24'd0, tx_data}, 32'h41);
    req      = '0;
    req_last = '0;
    tick();
    checkOutput("single_start_pulse", {31'd0, tx_start}, 0);
    repeat (18) tick();
    checkOutput("single_wait_grant", {28'd0, grant}, 32'h4);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checkOutput("single_release", {28'd0, grant}, 0);
    req = 4'b1001;
    tick();
    checkOutput("single_next_prio", {28'd0, grant}, 32'h8);

    rst_n = 1'b0;
    req   = '0;
    repeat (2) tick();
    rst_n     = 1'b1;
    model_ptr = 0;

    for (int r = 0; r < 8; r++) applyStimulus(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
